// File: rtl/sw_seq_pkg.sv
// Shared types and helpers for the switch-sequence player.
//   state_e    : player FSM states
//   SW_CODE_*  : 2-bit switch codes stored in code memory
//   sw_onehot  : code -> {SW4,SW3,SW2,SW1} one-hot drive
package sw_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SW_CODE_1 = 2'd0;
  localparam logic [1:0] SW_CODE_2 = 2'd1;
  localparam logic [1:0] SW_CODE_3 = 2'd2;
  localparam logic [1:0] SW_CODE_4 = 2'd3;

  function automatic logic [3:0] sw_onehot(input logic [1:0] code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/sw_code_mem.sv
// Code memory for the sequence player: DEPTH x 2-bit register file.
// Synchronous write, asynchronous read. Deliberately has no reset so a
// stored unlock code survives a board reset.
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : switch code to store
//   raddr_i  : read address
//   rdata_o  : switch code at raddr_i (combinational)
module sw_code_mem
  import sw_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [1:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [1:0]    rdata_o
);

  logic [1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH)) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : SW_CODE_1;

endmodule

// File: rtl/sw_sequence_player.sv
// Plays a stored sequence of switch codes as one-hot SW1..SW4 pulses:
// each step holds one switch for HOLD_CYCLES, then all switches low for
// GAP_CYCLES. Drives the switch inputs of the sequence lock directly.
//   clk, reset      : clock, synchronous active-high reset
//   load_en/idx/sw  : code memory write (only accepted while idle)
//   seq_len         : number of steps, sampled on accepted start
//   start, abort    : begin playback (idle only) / stop without done
//   SW1..SW4        : registered one-hot switch drive
//   busy, done      : not-idle flag, one-cycle completion pulse
//   step            : index of the step being played
module sw_sequence_player
  import sw_seq_pkg::*;
#(
  parameter int MAX_STEPS   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  localparam int IDXW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1,
  localparam int LENW = $clog2(MAX_STEPS + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [IDXW-1:0] load_idx,
  input  logic [1:0]      load_sw,
  input  logic [LENW-1:0] seq_len,
  input  logic            start,
  input  logic            abort,
  output logic            SW1,
  output logic            SW2,
  output logic            SW3,
  output logic            SW4,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] step
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [LENW-1:0] LEN_MAX   = LENW'(MAX_STEPS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDXW-1:0] step_q, step_d;
  logic [LENW-1:0] len_q, len_d;
  logic [3:0]      sw_q, sw_d;
  logic            done_q, done_d;

  logic            mem_we;
  logic [IDXW-1:0] rd_addr;
  logic [1:0]      rd_code;
  logic [1:0]      first_code;

  // Writes are locked out during playback so the sequence can't change under us.
  assign mem_we  = load_en && (state_q == ST_IDLE);
  // From GAP we fetch the next step; from IDLE the first one.
  assign rd_addr = (state_q == ST_GAP) ? (step_q + IDXW'(1)) : '0;

  sw_code_mem #(.DEPTH(MAX_STEPS), .AW(IDXW)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (load_idx),
    .wdata_i (load_sw),
    .raddr_i (rd_addr),
    .rdata_o (rd_code)
  );

  // A same-cycle write to slot 0 must be what the first step plays.
  assign first_code = (mem_we && (load_idx == '0)) ? load_sw : rd_code;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    len_d   = len_q;
    sw_d    = sw_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        sw_d = '0;
        if (start && !abort) begin
          step_d = '0;
          cnt_d  = '0;
          len_d  = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;
          if (seq_len == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HOLD;
            sw_d    = sw_onehot(first_code);
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          sw_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (LENW'(step_q) == len_q - LENW'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HOLD;
            step_d  = step_q + IDXW'(1);
            sw_d    = sw_onehot(rd_code);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      step_d  = '0;
      cnt_d   = '0;
      sw_d    = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      sw_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      len_q   <= len_d;
      sw_q    <= sw_d;
      done_q  <= done_d;
    end
  end

  assign SW1  = sw_q[0];
  assign SW2  = sw_q[1];
  assign SW3  = sw_q[2];
  assign SW4  = sw_q[3];
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign step = step_q;

endmodule

// File: tb/tb_sw_sequence_player.sv
// Directed bench for sw_sequence_player (MAX_STEPS=8, HOLD=4, GAP=2).
// Includes a small behavioural sequence lock fed by SW1..SW4.
module tb_sw_sequence_player;

  localparam int MAX = 8;
  localparam int H   = 4;
  localparam int G   = 2;
  localparam int P   = H + G;

  logic       clk = 1'b0;
  logic       reset, load_en, start, abort;
  logic [2:0] load_idx;
  logic [1:0] load_sw;
  logic [3:0] seq_len;
  logic       SW1, SW2, SW3, SW4, busy, done;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;
  int oh_err = 0;
  int dn_err = 0;
  logic done_prev = 1'b0;
  logic [1:0] exp_mem [MAX];

  // Lock model: SW1 press then SW2 press -> unlocked (state 2).
  logic       lock_rst;
  int         lock_st = 0;
  logic [3:0] sw_prev = '0;
  logic [3:0] sw_now, sw_rise;

  always #5 clk = ~clk;

  sw_sequence_player #(.MAX_STEPS(MAX), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_sw(load_sw), .seq_len(seq_len), .start(start), .abort(abort),
    .SW1(SW1), .SW2(SW2), .SW3(SW3), .SW4(SW4),
    .busy(busy), .done(done), .step(step)
  );

  assign sw_now  = {SW4, SW3, SW2, SW1};
  assign sw_rise = sw_now & ~sw_prev;

  always @(posedge clk) begin
    if (lock_rst) begin
      lock_st <= 0;
      sw_prev <= '0;
    end else begin
      sw_prev <= sw_now;
      if (sw_rise != 4'b0000) begin
        case (lock_st)
          0:       lock_st <= (sw_rise == 4'b0001) ? 1 : 0;
          1:       lock_st <= (sw_rise == 4'b0010) ? 2 : ((sw_rise == 4'b0001) ? 1 : 0);
          default: lock_st <= lock_st;
        endcase
      end
    end
  end

  // Invariants: at most one switch high; cycle after done is idle.
  always @(negedge clk) begin
    if (!$onehot0(sw_now)) oh_err <= oh_err + 1;
    if (done_prev && busy) dn_err <= dn_err + 1;
    done_prev <= done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [1:0] code);
    load_en  = 1'b1;
    load_idx = 3'(idx);
    load_sw  = code;
    exp_mem[idx] = code;
    tick();
    load_en = 1'b0;
  endtask

  // {SW4,SW3,SW2,SW1,done,busy} expected c cycles after start accepted.
  function automatic logic [5:0] exp_out(input int c, input int L);
    logic [3:0] sw;
    if (c >= 1 && c <= L * P) begin
      sw = ((c - 1) % P < H) ? (4'b0001 << exp_mem[(c - 1) / P]) : 4'b0000;
      return {sw, 1'b0, 1'b1};
    end else if (c == L * P + 1) begin
      return 6'b0000_11;
    end
    return 6'b0;
  endfunction

  function automatic logic [2:0] exp_step(input int c);
    return (c >= 1) ? 3'((c - 1) / P) : 3'd0;
  endfunction

  // Start playback and check every cycle; inj_c injects start+load mid-run.
  task automatic play_check(input string tag, input int sl, input int L,
                            input int ncyc, input int inj_c);
    seq_len = 4'(sl);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      chk($sformatf("%s_out@%0d", tag, c), 32'({sw_now, done, busy}), 32'(exp_out(c, L)));
      if (c <= L * P)
        chk($sformatf("%s_step@%0d", tag, c), 32'(step), 32'(exp_step(c)));
      else if (c > L * P + 1)
        chk($sformatf("%s_step@%0d", tag, c), 32'(step), 32'd0);
      if (c == inj_c) begin
        start    = 1'b1;
        load_en  = 1'b1;
        load_idx = 3'd0;
        load_sw  = 2'd3;
      end
      tick();
      start   = 1'b0;
      load_en = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; lock_rst = 1'b1;
    load_en = 1'b0; start = 1'b0; abort = 1'b0;
    load_idx = '0; load_sw = '0; seq_len = '0;
    for (int i = 0; i < MAX; i++) exp_mem[i] = 2'd0;
    tick(); tick(); tick();
    chk("rst_sw",   32'(sw_now), 32'd0);
    chk("rst_busy", 32'(busy),   32'd0);
    chk("rst_done", 32'(done),   32'd0);
    chk("rst_step", 32'(step),   32'd0);
    reset = 1'b0; lock_rst = 1'b0;

    // 1: basic two-step playback, drives the lock open
    load(0, 2'd0);
    load(1, 2'd1);
    play_check("t1", 2, 2, 15, -1);
    chk("t1_lock", 32'(lock_st), 32'd2);

    // start and abort together in idle: abort wins
    seq_len = 4'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy),   32'd0);
    chk("sa_sw",   32'(sw_now), 32'd0);

    // 2: zero-length sequence
    play_check("t2", 0, 0, 3, -1);

    // 3: seq_len clamps to MAX_STEPS
    load(0, 2'd3); load(1, 2'd2); load(2, 2'd1); load(3, 2'd0);
    load(4, 2'd0); load(5, 2'd1); load(6, 2'd2); load(7, 2'd3);
    play_check("t3", 12, 8, 50, -1);

    // 4: abort in second HOLD, then replay from step 0
    load(0, 2'd0);
    load(1, 2'd1);
    seq_len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("t4_out@%0d", c), 32'({sw_now, done, busy}), 32'(exp_out(c, 2)));
      if (c == 8) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk("t4_abort_out",  32'({sw_now, done, busy}), 32'd0);
    chk("t4_abort_step", 32'(step), 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t4_quiet@%0d", c), 32'({done, busy}), 32'd0);
      tick();
    end
    play_check("t4r", 2, 2, 14, -1);

    // 5: start+load mid-playback ignored; memory unchanged afterwards
    play_check("t5", 2, 2, 15, 3);
    play_check("t5m", 2, 2, 14, -1);

    // 6: reset during GAP, then replay
    seq_len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("t6_out@%0d", c), 32'({sw_now, done, busy}), 32'(exp_out(c, 2)));
      if (c == 5) reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    chk("t6_rst_out",  32'({sw_now, done, busy}), 32'd0);
    chk("t6_rst_step", 32'(step), 32'd0);
    play_check("t6r", 2, 2, 14, -1);

    tick();
    chk("onehot",    32'(oh_err), 32'd0);
    chk("done_idle", 32'(dn_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
